// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus per-channel stability counter for panel switches and
// tank-level sensor bits; emits a clean level and one-clock rise/fall/any strobes.
module input_debouncer #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0][CNT_W-1:0] count;
    logic [WIDTH-1:0][CNT_W-1:0] count_next;
    logic [WIDTH-1:0]            clean_next;
    logic [WIDTH-1:0]            rise_next;
    logic [WIDTH-1:0]            fall_next;

    // Metastability guard; runs every edge independent of the sample strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // A differing sample must persist for DEBOUNCE_CYCLES strobes; any agreeing sample restarts the count.
    always_comb begin
        count_next = count;
        clean_next = clean_out;
        rise_next  = '0;
        fall_next  = '0;
        if (sample_en) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == clean_out[i]) begin
                    count_next[i] = '0;
                end else if (count[i] == CNT_LAST) begin
                    count_next[i] = '0;
                    clean_next[i] = sync2[i];
                    rise_next[i]  = sync2[i];
                    fall_next[i]  = ~sync2[i];
                end else begin
                    count_next[i] = count[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            clean_out <= RESET_VALUE;
        end else begin
            count     <= count_next;
            clean_out <= clean_next;
        end
    end

    // Strobes are rebuilt every edge, so each lasts exactly one clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            any_change <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: three parameterisations share one stimulus stream and
// are checked against a sliding-window acceptance model plus directed vector tables.
module tb_input_debouncer;

    localparam int NDUT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [3:0] raw_in;

    logic [3:0] clean_o [NDUT];
    logic [3:0] rise_o  [NDUT];
    logic [3:0] fall_o  [NDUT];
    logic       any_o   [NDUT];

    always #5 clock = ~clock;

    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .RESET_VALUE(4'b0000)) dut_a (
        .clock(clock), .reset(reset), .sample_en(sample_en), .raw_in(raw_in),
        .clean_out(clean_o[0]), .rise_pulse(rise_o[0]), .fall_pulse(fall_o[0]), .any_change(any_o[0]));
    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .RESET_VALUE(4'b1100)) dut_b (
        .clock(clock), .reset(reset), .sample_en(sample_en), .raw_in(raw_in),
        .clean_out(clean_o[1]), .rise_pulse(rise_o[1]), .fall_pulse(fall_o[1]), .any_change(any_o[1]));
    input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .RESET_VALUE(4'b0000)) dut_c (
        .clock(clock), .reset(reset), .sample_en(sample_en), .raw_in(raw_in),
        .clean_out(clean_o[2]), .rise_pulse(rise_o[2]), .fall_pulse(fall_o[2]), .any_change(any_o[2]));

    int         dc_of [NDUT] = '{8, 8, 1};
    logic [3:0] rv_of [NDUT] = '{4'b0000, 4'b1100, 4'b0000};

    int n_cmp = 0;
    int n_err = 0;

    // Reference: raw reaches the decision two edges late; a channel flips once the
    // last DC strobe samples since its previous flip all disagree with the clean level.
    logic [3:0]  m_d1 [NDUT];
    logic [3:0]  m_d2 [NDUT];
    logic [3:0]  m_clean [NDUT];
    logic [3:0]  m_rise [NDUT];
    logic [3:0]  m_fall [NDUT];
    logic        m_any [NDUT];
    int unsigned m_win [NDUT][4];
    int          m_nv  [NDUT][4];

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_d1[k] = rv_of[k]; m_d2[k] = rv_of[k]; m_clean[k] = rv_of[k];
            m_rise[k] = '0; m_fall[k] = '0; m_any[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin m_win[k][c] = 0; m_nv[k][c] = 0; end
        end
    endfunction

    function automatic void model_edge(int k);
        int unsigned mask;
        int unsigned want;
        logic        s;
        mask = (32'd1 << dc_of[k]) - 32'd1;
        m_rise[k] = '0;
        m_fall[k] = '0;
        if (sample_en) begin
            for (int c = 0; c < 4; c++) begin
                s = m_d2[k][c];
                m_win[k][c] = (m_win[k][c] << 1) | {31'd0, s};
                if (m_nv[k][c] < dc_of[k]) m_nv[k][c]++;
                want = m_clean[k][c] ? 32'd0 : mask;
                if (m_nv[k][c] >= dc_of[k] && (m_win[k][c] & mask) == want) begin
                    m_clean[k][c] = s;
                    m_rise[k][c] = s;
                    m_fall[k][c] = ~s;
                    m_win[k][c] = 0;
                    m_nv[k][c] = 0;
                end
            end
        end
        m_any[k] = |(m_rise[k] | m_fall[k]);
        m_d2[k] = m_d1[k];
        m_d1[k] = raw_in;
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got clean/rise/fall/any=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s_model_dut%0d", tag, k),
                  {clean_o[k], rise_o[k], fall_o[k], any_o[k]},
                  {m_clean[k], m_rise[k], m_fall[k], m_any[k]});
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (reset) for (int k = 0; k < NDUT; k++) model_edge(k);
        #1;
        check_model(tag);
    endtask

    task automatic assert_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       se;
        int         k;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] raw, logic se, int k,
                                logic [3:0] clean, logic [3:0] rise, logic [3:0] fall);
        vec_t v;
        v.raw = raw; v.se = se; v.k = k;
        v.clean = clean; v.rise = rise; v.fall = fall; v.any = |(rise | fall);
        vecs.push_back(v);
    endfunction

    initial begin
        // After reset release with raw=0: dut_b (reset level 1100) drops bits 3:2 together at edge 10.
        for (int r = 1; r <= 12; r++)
            add(4'b0000, 1'b1, 1, (r < 10) ? 4'b1100 : 4'b0000, 4'b0000, (r == 10) ? 4'b1100 : 4'b0000);
        // raw[0] rises and stays: accepted on edge 10, strobe only on that edge.
        for (int r = 1; r <= 12; r++)
            add(4'b0001, 1'b1, 0, (r >= 10) ? 4'b0001 : 4'b0000, (r == 10) ? 4'b0001 : 4'b0000, 4'b0000);
        // raw[1] bounces high for 5 clocks, then settles high 10 edges later.
        for (int r = 1; r <= 10; r++)
            add((r <= 5) ? 4'b0011 : 4'b0001, 1'b1, 0, 4'b0001, 4'b0000, 4'b0000);
        for (int r = 11; r <= 22; r++)
            add(4'b0011, 1'b1, 0, (r >= 20) ? 4'b0011 : 4'b0001, (r == 20) ? 4'b0010 : 4'b0000, 4'b0000);
        // Strobe every 4th clock: raw[2] accepted on the 8th strobe (edge 32).
        for (int r = 1; r <= 36; r++)
            add(4'b0111, (r % 4) == 0, 0, (r >= 32) ? 4'b0111 : 4'b0011, (r == 32) ? 4'b0100 : 4'b0000, 4'b0000);

        raw_in = 4'b0000;
        sample_en = 1'b1;
        reset = 1'b1;
        #2;
        assert_reset("por");
        for (int r = 0; r < 3; r++) step("reset_hold");
        check("reset_dut_a", {clean_o[0], rise_o[0], fall_o[0], any_o[0]}, 13'b0000_0000_0000_0);
        check("reset_dut_b", {clean_o[1], rise_o[1], fall_o[1], any_o[1]}, 13'b1100_0000_0000_0);
        check("reset_dut_c", {clean_o[2], rise_o[2], fall_o[2], any_o[2]}, 13'b0000_0000_0000_0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            raw_in = vecs[i].raw;
            sample_en = vecs[i].se;
            step("vec");
            check($sformatf("vec%0d_dut%0d", i, vecs[i].k),
                  {clean_o[vecs[i].k], rise_o[vecs[i].k], fall_o[vecs[i].k], any_o[vecs[i].k]},
                  {vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].any});
        end

        // Reset while raw[0]'s fall is pending (counter at 5): cleared at once, no strobe.
        raw_in = 4'b0110;
        sample_en = 1'b1;
        for (int r = 0; r < 7; r++) step("pending");
        check("pending_hold_a", {clean_o[0], rise_o[0], fall_o[0], any_o[0]}, 13'b0111_0000_0000_0);
        assert_reset("midcount_rst");
        check("midcount_clear_a", {clean_o[0], rise_o[0], fall_o[0], any_o[0]}, 13'b0000_0000_0000_0);
        check("midcount_clear_b", {clean_o[1], rise_o[1], fall_o[1], any_o[1]}, 13'b1100_0000_0000_0);
        for (int r = 0; r < 2; r++) step("midcount_hold");
        reset = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            step("post_reset");
            check($sformatf("post_reset_edge%0d", r), {clean_o[0], rise_o[0], fall_o[0], any_o[0]},
                  {(r >= 10) ? 4'b0110 : 4'b0000, (r == 10) ? 4'b0110 : 4'b0000, 4'b0000, r == 10});
        end

        // Random soak: sparse toggles and short glitches, varying strobe rate, occasional async reset.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 9)
                raw_in = raw_in ^ (4'b0001 << $urandom_range(0, 3));
            case ((n / 500) % 3)
                0:       sample_en = 1'b1;
                1:       sample_en = $urandom_range(0, 1) == 1;
                default: sample_en = $urandom_range(0, 3) == 0;
            endcase
            if (!reset) begin
                if ($urandom_range(0, 2) == 0) reset = 1'b1;
            end else if ($urandom_range(0, 999) < 4) begin
                assert_reset("rand_rst");
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the panel switch inputs: sprinkler request, drip request, fertilizer request and the tank-level sensor bits.
- Runs before these signals reach the irrigation validation, the MEF1/MEF2 machines and the tank-level logic.
- Each raw switch is synchronized to `clock` and debounced with a per-channel stability counter.
- Outputs are a clean level per channel plus one-cycle rise, fall and any-change strobes, so downstream FSMs see exactly one edge per physical press.

Parameters:
- WIDTH, 4, number of independent input channels.
- DEBOUNCE_CYCLES, 8, consecutive sample_en strobes a new value must stay stable before acceptance; legal range 1..255.
- RESET_VALUE, 0 (WIDTH bits), value loaded into clean_out on reset.

Ports:
- clock  input  1  single system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is sampled on `clock`.
- sample_en  input  1  sampling strobe from the clock divider chain; tie to 1 to sample every cycle.
- raw_in  input  WIDTH  raw, asynchronous switch and sensor levels.
- clean_out  output  WIDTH  debounced, stable level per channel.
- rise_pulse  output  WIDTH  one-clock strobe when clean_out[i] goes 0->1.
- fall_pulse  output  WIDTH  one-clock strobe when clean_out[i] goes 1->0.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits; registered and aligned with them.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync1 and sync2 are cleared to RESET_VALUE.
  - clean_out is set to RESET_VALUE; all counters to 0.
  - rise_pulse, fall_pulse and any_change are set to 0.
- Synchronizer:
  - Two flops per channel (raw_in -> sync1 -> sync2), clocked every edge regardless of sample_en.
- Per channel i, at each edge with sample_en=1:
  - sync2[i]==clean_out[i]: counter[i] <= 0, no pulse.
  - sync2[i]!=clean_out[i] and counter[i]==DEBOUNCE_CYCLES-1: clean_out[i] <= sync2[i], counter[i] <= 0, and the matching rise/fall bit is set on the same edge.
  - Otherwise: counter[i] <= counter[i]+1.
- At each edge with sample_en=0:
  - Counters and clean_out hold.
  - All pulse bits and any_change are driven to 0.
- Pulse length: each pulse is high for exactly one clock and cleared on the next edge, even if sample_en stays high.
- Counter width is clog2(DEBOUNCE_CYCLES)+1 bits; the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Latency with sample_en tied to 1: a raw change that is stable from before edge 1 appears on clean_out at edge DEBOUNCE_CYCLES+2 (2 synchronizer edges plus DEBOUNCE_CYCLES samples).
- Glitch rejection: if sync2 returns to clean_out before acceptance, the counter clears and no pulse is produced. A bounce restarts the full count.
- Channels are fully independent:
  - Several channels may accept on the same edge; each gets its own pulse bit.
  - any_change is high once for that edge.
- DEBOUNCE_CYCLES=1: the first differing sample is accepted immediately.
- Reset asserted mid-count discards the pending change with no pulse. After release, a still-different input needs the full latency again.

Test Plan:
- Reset hold, then release with raw_in=4'b0000, sample_en=1 -> clean_out=0, no pulses, all counters 0.
- raw_in[0] 0->1 held stable, DEBOUNCE_CYCLES=8 -> clean_out[0] rises at edge 10; rise_pulse[0] and any_change high for exactly that one cycle.
- raw_in[1] toggles high for 5 clocks and then low (bounce) -> clean_out[1] stays 0 with no pulses. A following stable high accepts 10 edges after its own start.
- raw_in[3:2] both fall from 1 to 0 on the same cycle (RESET_VALUE=4'b1100) -> fall_pulse=4'b1100 on a single edge, any_change high for one cycle.
- sample_en=1 only every 4th clock, raw_in[2] 0->1 -> acceptance after 8 strobes; counters hold between strobes; pulse lasts one clock.
- reset asserted when counter[0]=5 while a change is pending -> outputs clear immediately. After release with input unchanged, acceptance takes the full 10 edges.
